// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RISC-V load/store funct3 encodings
//   - FSM state encoding
//   - access-size and request-legality helpers
package lsu_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR,
    RESP
  } state_e;

  // Access size in bytes (1/2/4/8). Only funct3[1:0] matters.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  // Byte-lane mask of an access before it is shifted to its offset.
  function automatic logic [7:0] byte_mask(input logic [2:0] funct3);
    logic [7:0] mask;
    case (funct3[1:0])
      2'b00:   mask = 8'h01;
      2'b01:   mask = 8'h03;
      2'b10:   mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // A request is rejected when it is misaligned for its size, uses the
  // unassigned funct3, or asks for an "unsigned" store (funct3[2]=1).
  function automatic logic req_error(input logic [2:0] funct3,
                                     input logic       write,
                                     input logic [2:0] offset);
    logic [2:0] low_mask;
    low_mask = 3'(size_bytes(funct3) - 4'd1);
    return (funct3 == F3_ILL) || (write && funct3[2]) ||
           ((offset & low_mask) != 3'b000);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering between a 64-bit memory line and the
// right-justified register view of a load or store.
//   line        : doubleword read from memory
//   offset      : byte offset of the access inside the line
//   funct3      : RISC-V load/store funct3 (selects size and extension)
//   wdata       : right-justified store data
//   load_value  : extracted, sign/zero-extended load result
//   merged_line : line with the low size bytes of wdata written at offset
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] line,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_value,
  output logic [XLEN-1:0] merged_line
);

  localparam int NBYTES = XLEN / 8;

  logic [5:0]        bit_shift;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   wdata_shifted;
  logic [NBYTES-1:0] byte_en;

  assign bit_shift     = {offset, 3'b000};
  assign shifted       = line >> bit_shift;
  assign wdata_shifted = wdata << bit_shift;

  // NOTE: every output of an always_comb gets a default before the case so
  // that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    load_value = '0;
    case (funct3)
      F3_B:    load_value = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_H:    load_value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:    load_value = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_D:    load_value = shifted;
      F3_BU:   load_value = {{(XLEN-8){1'b0}},  shifted[7:0]};
      F3_HU:   load_value = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_WU:   load_value = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_value = '0;
    endcase
  end

  // Aligned accesses never straddle the line, so the shifted mask cannot
  // overflow past the top byte.
  always_comb begin
    byte_en     = NBYTES'(byte_mask(funct3)) << offset;
    merged_line = line;
    for (int k = 0; k < NBYTES; k++) begin
      if (byte_en[k]) merged_line[8*k +: 8] = wdata_shifted[8*k +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a doubleword-addressed memory.
// Converts byte/half/word/double loads and stores into aligned 64-bit
// accesses; sub-doubleword stores use read-modify-write.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (one request in flight)
//   req_write, req_funct3 : store/load select and RISC-V funct3
//   req_addr, req_wdata   : byte address and right-justified store data
//   resp_valid            : one-cycle completion pulse
//   resp_rdata            : extended load data (0 for stores/errors)
//   resp_misaligned       : request rejected (misaligned or illegal)
//   mem_address, mem_writeData, MemRead, MemWrite, mem_readData :
//                           DataMemory interface, address always aligned
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int MEM_RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_writeData,
  output logic            MemRead,
  output logic            MemWrite,
  input  logic [XLEN-1:0] mem_readData
);

  localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

  state_e          state, state_next;
  logic [2:0]      funct3_q;
  logic            write_q;
  logic [2:0]      offset_q;
  logic [XLEN-1:0] base_q;
  // Holds the store data until the read line arrives, then the merged line.
  logic [XLEN-1:0] line_q;
  logic [XLEN-1:0] rdata_q;
  logic            misaligned_q;
  logic [CNT_W-1:0] lat_cnt;
  logic            lat_done;
  logic            req_err;
  logic [XLEN-1:0] load_value;
  logic [XLEN-1:0] merged_line;

  assign req_err  = req_error(req_funct3, req_write, req_addr[2:0]);
  assign lat_done = (lat_cnt == CNT_W'(MEM_RD_LAT - 1));

  lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
    .line        (mem_readData),
    .offset      (offset_q),
    .funct3      (funct3_q),
    .wdata       (line_q),
    .load_value  (load_value),
    .merged_line (merged_line)
  );

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                           state_next = RESP;
          else if (req_write && req_funct3 == F3_D) state_next = WR;
          else                                   state_next = RD_ISSUE;
        end
      end
      RD_ISSUE:   state_next = RD_CAPTURE;
      RD_CAPTURE: if (lat_done) state_next = write_q ? WR : RESP;
      WR:         state_next = RESP;
      RESP:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Memory strobes come straight from the state, so they are mutually
  // exclusive and drop the cycle after a reset edge.
  always_comb begin
    req_ready       = (state == IDLE);
    MemRead         = (state == RD_ISSUE) || (state == RD_CAPTURE);
    MemWrite        = (state == WR);
    mem_address     = base_q;
    mem_writeData   = (state == WR) ? line_q : '0;
    resp_valid      = (state == RESP);
    resp_rdata      = (state == RESP) ? rdata_q : '0;
    resp_misaligned = (state == RESP) ? misaligned_q : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      funct3_q     <= '0;
      write_q      <= 1'b0;
      offset_q     <= '0;
      base_q       <= '0;
      line_q       <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      lat_cnt      <= '0;
    end else begin
      lat_cnt <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q     <= req_funct3;
            write_q      <= req_write;
            offset_q     <= req_addr[2:0];
            base_q       <= {req_addr[XLEN-1:3], 3'b000};
            line_q       <= req_wdata;
            rdata_q      <= '0;
            misaligned_q <= req_err;
          end
        end
        RD_CAPTURE: begin
          if (lat_done) begin
            if (write_q) line_q  <= merged_line;
            else         rdata_q <= load_value;
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
